// File: rtl/mathblock_mac_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mathblock_mac_arbiter_if
// Description : Request/result bundle between fabric clients and the shared
//               multiply-add arbiter. The arbiter side uses 'slave', the
//               client/test side uses 'master'.
// Revision    : 1.0 - initial release
// ============================================================================
interface mathblock_mac_arbiter_if #(
    parameter int NUM_REQ  = 4,
    parameter int A_WIDTH  = 18,
    parameter int P_WIDTH  = 44,
    parameter int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    // Per-requester request channel, operands packed requester-major
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ-1:0]         req_uns;
    logic [NUM_REQ*A_WIDTH-1:0] req_a;
    logic [NUM_REQ*A_WIDTH-1:0] req_b;
    logic [NUM_REQ*P_WIDTH-1:0] req_c;

    // Shared, tagged result channel
    logic                       res_valid;
    logic                       res_ready;
    logic [ID_WIDTH-1:0]        res_id;
    logic [P_WIDTH-1:0]         res_p;

    modport slave (
        input  req_valid,
        input  req_uns,
        input  req_a,
        input  req_b,
        input  req_c,
        input  res_ready,
        output req_ready,
        output res_valid,
        output res_id,
        output res_p
    );

    modport master (
        output req_valid,
        output req_uns,
        output req_a,
        output req_b,
        output req_c,
        output res_ready,
        input  req_ready,
        input  res_valid,
        input  res_id,
        input  res_p
    );
endinterface
`default_nettype wire

// File: rtl/mathblock_mac_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mathblock_mac_arbiter
// Description : Round-robin scheduler sharing one two-stage pipelined
//               multiply-add (p = a*b + c) between NUM_REQ requesters.
//               Signed 18x18 or unsigned 17x17 per request, results returned
//               in issue order tagged with the requester index.
// Revision    : 1.0 - initial release
// ============================================================================
module mathblock_mac_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int A_WIDTH  = 18,
    parameter int P_WIDTH  = 44,
    parameter int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    mathblock_mac_arbiter_if.slave   bus
);

    // One extra operand bit lets signed and unsigned ops share a signed multiply
    localparam int                c_op_width   = A_WIDTH + 1;
    localparam int                c_prod_width = 2 * c_op_width;
    localparam logic [ID_WIDTH:0] c_num_req    = (ID_WIDTH+1)'(NUM_REQ);
    localparam logic [ID_WIDTH-1:0] c_last_id  = ID_WIDTH'(NUM_REQ - 1);

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic                   w_en;
    logic                   w_any;
    logic                   w_accept;
    logic [ID_WIDTH-1:0]    w_grant_idx;
    logic [NUM_REQ-1:0]     w_ready;
    logic [ID_WIDTH-1:0]    w_cand [NUM_REQ];

    logic [A_WIDTH-1:0]     w_a [NUM_REQ];
    logic [A_WIDTH-1:0]     w_b [NUM_REQ];
    logic [P_WIDTH-1:0]     w_c [NUM_REQ];

    logic [ID_WIDTH-1:0]    r_last_grant;

    logic                   r_s1_valid;
    logic [A_WIDTH-1:0]     r_s1_a;
    logic [A_WIDTH-1:0]     r_s1_b;
    logic [P_WIDTH-1:0]     r_s1_c;
    logic                   r_s1_uns;
    logic [ID_WIDTH-1:0]    r_s1_id;

    logic signed [c_op_width-1:0]   w_op_a;
    logic signed [c_op_width-1:0]   w_op_b;
    logic signed [c_prod_width-1:0] w_prod;
    logic [P_WIDTH-1:0]             w_prod_ext;
    logic [P_WIDTH-1:0]             w_res_p;

    logic                   r_res_valid;
    logic [ID_WIDTH-1:0]    r_res_id;
    logic [P_WIDTH-1:0]     r_res_p;

    // ------------------------------------------------------------------
    // Per-requester operand unpacking and round-robin search order.
    // Candidate k is requester (last_grant + 1 + k) mod NUM_REQ, so
    // candidate 0 is the highest-priority requester this cycle.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            localparam logic [ID_WIDTH:0] c_step = (ID_WIDTH+1)'(gi + 1);

            logic [ID_WIDTH:0] w_sum;

            assign w_a[gi] = bus.req_a[gi*A_WIDTH +: A_WIDTH];
            assign w_b[gi] = bus.req_b[gi*A_WIDTH +: A_WIDTH];
            assign w_c[gi] = bus.req_c[gi*P_WIDTH +: P_WIDTH];

            // Sum never exceeds 2*NUM_REQ-1, so one conditional subtract wraps it
            assign w_sum      = {1'b0, r_last_grant} + c_step;
            assign w_cand[gi] = (w_sum >= c_num_req) ? ID_WIDTH'(w_sum - c_num_req)
                                                     : w_sum[ID_WIDTH-1:0];
        end
    endgenerate

    // Pipeline advances whenever the output register is empty or being drained
    assign w_en     = !r_res_valid || bus.res_ready;
    assign w_accept = w_any && w_en && reset_n;

    // Pick the first valid requester in round-robin order (lowest k wins)
    always_comb begin
        w_any       = 1'b0;
        w_grant_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[w_cand[k]]) begin
                w_any       = 1'b1;
                w_grant_idx = w_cand[k];
            end
        end
    end

    // One-hot ready to the granted requester, only when it will be accepted
    always_comb begin
        w_ready = '0;
        if (w_accept) begin
            w_ready[w_grant_idx] = 1'b1;
        end
    end

    assign bus.req_ready = w_ready;

    // Round-robin pointer moves only on an actual accept
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_last_grant <= c_last_id;
        end else if (w_accept) begin
            r_last_grant <= w_grant_idx;
        end
    end

    // Stage 1: capture the granted requester's operation (bubble if none)
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_c     <= '0;
            r_s1_uns   <= 1'b0;
            r_s1_id    <= '0;
        end else if (w_en) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_a   <= w_a[w_grant_idx];
                r_s1_b   <= w_b[w_grant_idx];
                r_s1_c   <= w_c[w_grant_idx];
                r_s1_uns <= bus.req_uns[w_grant_idx];
                r_s1_id  <= w_grant_idx;
            end
        end
    end

    // Operand conditioning: unsigned ops clear the top bit and extend with
    // zero; signed ops sign-extend. Both then fit one signed multiplier.
    always_comb begin
        if (r_s1_uns) begin
            w_op_a = {2'b00, r_s1_a[A_WIDTH-2:0]};
            w_op_b = {2'b00, r_s1_b[A_WIDTH-2:0]};
        end else begin
            w_op_a = {r_s1_a[A_WIDTH-1], r_s1_a};
            w_op_b = {r_s1_b[A_WIDTH-1], r_s1_b};
        end
    end

    // Product is sign-extended (zero for unsigned, since it is non-negative)
    // and added to c; the sum wraps modulo 2^P_WIDTH.
    assign w_prod     = w_op_a * w_op_b;
    assign w_prod_ext = P_WIDTH'(w_prod);
    assign w_res_p    = w_prod_ext + r_s1_c;

    // Stage 2: result register, frozen under backpressure
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_res_valid <= 1'b0;
            r_res_id    <= '0;
            r_res_p     <= '0;
        end else if (w_en) begin
            r_res_valid <= r_s1_valid;
            r_res_id    <= r_s1_id;
            r_res_p     <= w_res_p;
        end
    end

    assign bus.res_valid = r_res_valid;
    assign bus.res_id    = r_res_id;
    assign bus.res_p     = r_res_p;

endmodule
`default_nettype wire

// File: tb/tb_mathblock_mac_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mathblock_mac_arbiter
// Description : Self-checking bench for mathblock_mac_arbiter: table of
//               single operations plus fairness, backpressure and
//               mid-operation reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mathblock_mac_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int A_WIDTH  = 18;
    localparam int P_WIDTH  = 44;
    localparam int ID_WIDTH = 2;

    typedef struct {
        int                 id;
        logic [A_WIDTH-1:0] a;
        logic [A_WIDTH-1:0] b;
        logic [P_WIDTH-1:0] c;
        logic               uns;
        logic [P_WIDTH-1:0] p;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;

    int checks = 0;
    int errors = 0;

    vec_t               vecs [8];
    logic [P_WIDTH-1:0] q [$];

    always #5 clk = ~clk;

    mathblock_mac_arbiter_if #(
        .NUM_REQ (NUM_REQ),
        .A_WIDTH (A_WIDTH),
        .P_WIDTH (P_WIDTH),
        .ID_WIDTH(ID_WIDTH)
    ) bus ();

    mathblock_mac_arbiter #(
        .NUM_REQ (NUM_REQ),
        .A_WIDTH (A_WIDTH),
        .P_WIDTH (P_WIDTH),
        .ID_WIDTH(ID_WIDTH)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        bus.req_valid = '0;
        bus.req_uns   = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_c     = '0;
    endtask

    task automatic set_req(input int id, input logic [A_WIDTH-1:0] a, input logic [A_WIDTH-1:0] b,
                           input logic [P_WIDTH-1:0] c, input logic uns);
        bus.req_valid[id]                  = 1'b1;
        bus.req_uns[id]                    = uns;
        bus.req_a[id*A_WIDTH +: A_WIDTH]   = a;
        bus.req_b[id*A_WIDTH +: A_WIDTH]   = b;
        bus.req_c[id*P_WIDTH +: P_WIDTH]   = c;
    endtask

    // Safety net: any stuck sequence still ends with a FAIL line
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [P_WIDTH-1:0]  last_p;
        logic [ID_WIDTH-1:0] last_id;
        logic                prev_stall;
        int                  n;
        int                  pops;

        // id, a, b, c, uns, expected p
        vecs[0] = '{0, 18'h3FFFD, 18'd5,      44'd100,          1'b0, 44'd85};
        vecs[1] = '{2, 18'h3FFFF, 18'h1FFFF,  44'd0,            1'b1, 44'h3FFFC0001};
        vecs[2] = '{1, 18'h20000, 18'h20000,  44'h7FFFFFFFFFF,  1'b0, 44'h803FFFFFFFF};
        vecs[3] = '{3, 18'h3FFFF, 18'h3FFFF,  44'd0,            1'b0, 44'd1};
        vecs[4] = '{3, 18'h20001, 18'd7,      44'd10,           1'b1, 44'h11};
        vecs[5] = '{0, 18'd100,   18'h3FFFE,  44'd0,            1'b0, 44'hFFFFFFFFF38};
        vecs[6] = '{1, 18'h20000, 18'h1FFFF,  44'd0,            1'b0, 44'hFFC00020000};
        vecs[7] = '{2, 18'd0,     18'd0,      44'hFFFFFFFFFFF,  1'b1, 44'hFFFFFFFFFFF};

        // ---------------- reset state, requests pending during reset ----------
        reset_n       = 1'b0;
        clear_req();
        bus.req_valid = 4'hF;
        bus.res_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("reset req_ready", 64'(bus.req_ready), 64'd0);
        chk("reset res_valid", 64'(bus.res_valid), 64'd0);
        chk("reset res_id",    64'(bus.res_id),    64'd0);
        chk("reset res_p",     64'(bus.res_p),     64'd0);
        tick();
        reset_n = 1'b1;
        clear_req();

        // ---------------- table of single operations ------------------------
        for (int i = 0; i < 8; i++) begin
            tick();
            clear_req();
            set_req(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].uns);
            @(negedge clk);
            chk($sformatf("vec%0d req_ready", i), 64'(bus.req_ready), 64'(4'b0001 << vecs[i].id));
            tick();
            clear_req();
            @(negedge clk);
            chk($sformatf("vec%0d early res_valid", i), 64'(bus.res_valid), 64'd0);
            tick();
            @(negedge clk);
            chk($sformatf("vec%0d res_valid", i), 64'(bus.res_valid), 64'd1);
            chk($sformatf("vec%0d res_id", i),    64'(bus.res_id),    64'(vecs[i].id));
            chk($sformatf("vec%0d res_p", i),     64'(bus.res_p),     64'(vecs[i].p));
        end

        // ---------------- fairness: all requesters valid -------------------
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int r = 0; r < NUM_REQ; r++) begin
            set_req(r, 18'(r + 1), 18'd1, 44'd0, 1'b0);
        end
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (cyc < 8) begin
                chk($sformatf("rr grant cyc%0d", cyc), 64'(bus.req_ready), 64'(4'b0001 << (cyc % 4)));
            end
            if (cyc >= 2) begin
                chk($sformatf("rr res_valid cyc%0d", cyc), 64'(bus.res_valid), 64'd1);
                chk($sformatf("rr res_id cyc%0d", cyc),    64'(bus.res_id),    64'((cyc - 2) % 4));
                chk($sformatf("rr res_p cyc%0d", cyc),     64'(bus.res_p),     64'((cyc - 2) % 4 + 1));
            end
        end
        tick();
        clear_req();
        tick();
        tick();
        tick();

        // ---------------- backpressure on a stream from requester 1 --------
        n          = 1;
        pops       = 0;
        prev_stall = 1'b0;
        last_p     = '0;
        last_id    = '0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            tick();
            bus.res_ready = !(cyc >= 5 && cyc <= 7);
            clear_req();
            if (cyc < 11) begin
                set_req(1, 18'(n), 18'd3, 44'(n), 1'b0);
            end
            @(negedge clk);
            if (prev_stall) begin
                chk($sformatf("bp hold res_p cyc%0d", cyc),  64'(bus.res_p),  64'(last_p));
                chk($sformatf("bp hold res_id cyc%0d", cyc), 64'(bus.res_id), 64'(last_id));
            end
            if (bus.res_valid && !bus.res_ready) begin
                chk($sformatf("bp stall req_ready cyc%0d", cyc), 64'(bus.req_ready), 64'd0);
            end
            if (bus.res_valid && bus.res_ready) begin
                pops++;
                if (q.size() == 0) begin
                    chk($sformatf("bp unexpected result cyc%0d", cyc), 64'(bus.res_p), 64'd0 - 64'd1);
                end else begin
                    chk($sformatf("bp res_p cyc%0d", cyc),  64'(bus.res_p),  64'(q.pop_front()));
                    chk($sformatf("bp res_id cyc%0d", cyc), 64'(bus.res_id), 64'd1);
                end
            end
            if (bus.req_ready[1]) begin
                q.push_back(44'(4 * n));
                n++;
            end
            prev_stall = bus.res_valid && !bus.res_ready;
            last_p     = bus.res_p;
            last_id    = bus.res_id;
        end
        for (int cyc = 0; cyc < 4; cyc++) begin
            tick();
            bus.res_ready = 1'b1;
            clear_req();
            @(negedge clk);
            if (bus.res_valid) begin
                pops++;
                if (q.size() == 0) begin
                    chk("bp drain unexpected result", 64'(bus.res_p), 64'd0 - 64'd1);
                end else begin
                    chk($sformatf("bp drain res_p %0d", cyc), 64'(bus.res_p), 64'(q.pop_front()));
                end
            end
        end
        chk("bp accepted count", 64'(n - 1), 64'd8);
        chk("bp result count",   64'(pops),  64'd8);
        chk("bp queue empty",    64'(q.size()), 64'd0);

        // ---------------- reset in the middle of operations ----------------
        tick();
        clear_req();
        set_req(2, 18'd4, 18'd4, 44'd0, 1'b0);
        set_req(3, 18'd5, 18'd5, 44'd0, 1'b0);
        tick();
        tick();
        reset_n       = 1'b0;
        bus.req_valid = 4'hF;
        @(negedge clk);
        chk("mid reset req_ready", 64'(bus.req_ready), 64'd0);
        tick();
        reset_n = 1'b1;
        clear_req();
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clk);
            chk($sformatf("post reset res_valid cyc%0d", cyc), 64'(bus.res_valid), 64'd0);
            tick();
        end
        bus.req_valid = 4'hF;
        @(negedge clk);
        chk("post reset first grant", 64'(bus.req_ready), 64'd1);
        tick();
        clear_req();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
